// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default geometry and Gray/binary code helpers.
// Used by both the read-side and write-side pointer generators.
package fifo_pkg;

  localparam int unsigned DEF_ADDR_SIZE = 4;
  localparam int unsigned FIFO_DEPTH    = 2 ** DEF_ADDR_SIZE;

  // Helpers work on a wide word; callers zero-extend in and truncate out,
  // which is exact for both conversions since upper zero bits stay zero.
  localparam int unsigned CODE_W = 32;

  function automatic logic [CODE_W-1:0] bin2gray(input logic [CODE_W-1:0] bin);
    return (bin >> 1) ^ bin;
  endfunction

  function automatic logic [CODE_W-1:0] gray2bin(input logic [CODE_W-1:0] gray);
    logic [CODE_W-1:0] bin;
    bin[CODE_W-1] = gray[CODE_W-1];
    for (int i = CODE_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of all
// Gray bits at and above its position.
module gray_to_bin #(
  parameter int unsigned WIDTH = 5
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // Prefix XOR from the MSB down.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin[i] = ^gray[WIDTH-1:i];
  end

endmodule

// File: rtl/read_pointer_gen.sv
// Read-side pointer and flag generator for the asynchronous FIFO.
// Produces the binary read address, the Gray read pointer for the write
// domain, and registered empty / almost-empty / level / underflow status.
// Build option: define RD_UNDERFLOW_STICKY_EN to make rd_underflow sticky
// until rd_rst; otherwise it pulses once per illegal rd_inc cycle.
module read_pointer_gen
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = DEF_ADDR_SIZE,
  parameter int unsigned AE_THRESH = 2
) (
  input  logic                 rd_clk,
  input  logic                 rd_rst,
  input  logic                 rd_inc,
  input  logic [ADDR_SIZE:0]   sync_wrt_ptr,
  output logic [ADDR_SIZE-1:0] rd_addr,
  output logic [ADDR_SIZE:0]   rd_ptr,
  output logic                 rd_empty,
  output logic                 rd_almost_empty,
  output logic [ADDR_SIZE:0]   rd_level,
  output logic                 rd_underflow
);

  localparam int unsigned PTR_W = ADDR_SIZE + 1;

  logic [PTR_W-1:0] rd_bin;
  logic [PTR_W-1:0] rd_bin_nxt;
  logic [PTR_W-1:0] rd_gray_nxt;
  logic [PTR_W-1:0] wbin;
  logic [PTR_W-1:0] level_nxt;
  logic             pop_c;
  logic             underflow_c;
  logic             empty_nxt;
  logic             almost_empty_nxt;
  logic             underflow_nxt;

  // Synchronised write pointer back to binary for the level subtraction.
  gray_to_bin #(
    .WIDTH (PTR_W)
  ) u_wptr_g2b (
    .gray (sync_wrt_ptr),
    .bin  (wbin)
  );

  // Next pointer, flags and level; a pop and a write update on the same
  // edge are both folded in with no priority between them.
  always_comb begin
    pop_c            = rd_inc & ~rd_empty;
    underflow_c      = rd_inc & rd_empty;
    rd_bin_nxt       = rd_bin + PTR_W'(pop_c);
    rd_gray_nxt      = PTR_W'(bin2gray(CODE_W'(rd_bin_nxt)));
    empty_nxt        = (rd_gray_nxt == sync_wrt_ptr);
    level_nxt        = wbin - rd_bin_nxt;
    almost_empty_nxt = (32'(level_nxt) <= AE_THRESH);
`ifdef RD_UNDERFLOW_STICKY_EN
    underflow_nxt    = rd_underflow | underflow_c;
`else
    underflow_nxt    = underflow_c;
`endif
  end

  // Read-domain state registers.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      rd_bin          <= '0;
      rd_ptr          <= '0;
      rd_empty        <= 1'b1;
      rd_almost_empty <= 1'b1;
      rd_level        <= '0;
      rd_underflow    <= 1'b0;
    end else begin
      rd_bin          <= rd_bin_nxt;
      rd_ptr          <= rd_gray_nxt;
      rd_empty        <= empty_nxt;
      rd_almost_empty <= almost_empty_nxt;
      rd_level        <= level_nxt;
      rd_underflow    <= underflow_nxt;
    end
  end

  // Memory address is the low bits of the binary pointer register.
  assign rd_addr = rd_bin[ADDR_SIZE-1:0];

endmodule

// File: tb/tb_read_pointer_gen.sv
// Directed, table-driven bench for read_pointer_gen (ADDR_SIZE=4, AE_THRESH=2).
module tb_read_pointer_gen;

  logic       rd_clk = 1'b0;
  logic       rd_rst = 1'b0;
  logic       rd_inc = 1'b0;
  logic [4:0] sync_wrt_ptr = 5'b00000;
  logic [3:0] rd_addr;
  logic [4:0] rd_ptr;
  logic       rd_empty;
  logic       rd_almost_empty;
  logic [4:0] rd_level;
  logic       rd_underflow;

  int errors = 0;
  int checks = 0;

  read_pointer_gen #(
    .ADDR_SIZE (4),
    .AE_THRESH (2)
  ) dut (
    .rd_clk          (rd_clk),
    .rd_rst          (rd_rst),
    .rd_inc          (rd_inc),
    .sync_wrt_ptr    (sync_wrt_ptr),
    .rd_addr         (rd_addr),
    .rd_ptr          (rd_ptr),
    .rd_empty        (rd_empty),
    .rd_almost_empty (rd_almost_empty),
    .rd_level        (rd_level),
    .rd_underflow    (rd_underflow)
  );

  always #5 rd_clk = ~rd_clk;

  typedef struct {
    logic       rst;
    logic       inc;
    logic [4:0] wp;
    logic [3:0] addr;
    logic [4:0] ptr;
    logic       empty;
    logic       ae;
    logic [4:0] level;
    logic       uf;
  } vec_t;

  vec_t vecs[$];

`ifdef RD_UNDERFLOW_STICKY_EN
  localparam logic UF_AFTER = 1'b1;
`else
  localparam logic UF_AFTER = 1'b0;
`endif

  // Gray codes 0..16 for 5-bit pointers, written out by hand.
  logic [4:0] gray_tab [0:16] = '{
    5'b00000, 5'b00001, 5'b00011, 5'b00010, 5'b00110, 5'b00111, 5'b00101,
    5'b00100, 5'b01100, 5'b01101, 5'b01111, 5'b01110, 5'b01010, 5'b01011,
    5'b01001, 5'b01000, 5'b11000
  };

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " addr"},  32'(rd_addr), 32'd0);
    check({tag, " ptr"},   32'(rd_ptr), 32'd0);
    check({tag, " empty"}, 32'(rd_empty), 32'd1);
    check({tag, " ae"},    32'(rd_almost_empty), 32'd1);
    check({tag, " level"}, 32'(rd_level), 32'd0);
    check({tag, " uf"},    32'(rd_underflow), 32'd0);
  endtask

  task automatic add(input logic rst, input logic inc, input logic [4:0] wp,
                     input logic [3:0] addr, input logic [4:0] ptr, input logic empty,
                     input logic ae, input logic [4:0] level, input logic uf);
    vec_t v;
    v.rst = rst; v.inc = inc; v.wp = wp; v.addr = addr; v.ptr = ptr;
    v.empty = empty; v.ae = ae; v.level = level; v.uf = uf;
    vecs.push_back(v);
  endtask

  task automatic clear_state();
    @(negedge rd_clk);
    rd_rst = 1'b1; rd_inc = 1'b0; sync_wrt_ptr = 5'b00000;
    @(negedge rd_clk);
    rd_rst = 1'b0;
  endtask

  task automatic run_vecs(input string tag);
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge rd_clk);
      rd_rst = vecs[i].rst; rd_inc = vecs[i].inc; sync_wrt_ptr = vecs[i].wp;
      @(posedge rd_clk);
      #1;
      check($sformatf("%s[%0d] addr", tag, i),  32'(rd_addr), 32'(vecs[i].addr));
      check($sformatf("%s[%0d] ptr", tag, i),   32'(rd_ptr), 32'(vecs[i].ptr));
      check($sformatf("%s[%0d] empty", tag, i), 32'(rd_empty), 32'(vecs[i].empty));
      check($sformatf("%s[%0d] ae", tag, i),    32'(rd_almost_empty), 32'(vecs[i].ae));
      check($sformatf("%s[%0d] level", tag, i), 32'(rd_level), 32'(vecs[i].level));
      check($sformatf("%s[%0d] uf", tag, i),    32'(rd_underflow), 32'(vecs[i].uf));
    end
    vecs.delete();
  endtask

  initial begin
    logic [4:0] prev_ptr;

    // Reset asserted between edges takes effect immediately.
    repeat (2) @(posedge rd_clk);
    @(negedge rd_clk);
    rd_rst = 1'b1;
    #1;
    check_reset_vals("async_reset");
    @(negedge rd_clk);
    rd_rst = 1'b0;

    // Drain to empty, then underflow while empty, then reset clears it.
    //   rst inc  wp        addr ptr       e  ae lvl     uf
    add(0, 0, 5'b00010, 4'd0, 5'b00000, 0, 0, 5'd3, 0);
    add(0, 1, 5'b00010, 4'd1, 5'b00001, 0, 1, 5'd2, 0);
    add(0, 1, 5'b00010, 4'd2, 5'b00011, 0, 1, 5'd1, 0);
    add(0, 1, 5'b00010, 4'd3, 5'b00010, 1, 1, 5'd0, 0);
    add(0, 1, 5'b00010, 4'd3, 5'b00010, 1, 1, 5'd0, 1);
    add(0, 1, 5'b00010, 4'd3, 5'b00010, 1, 1, 5'd0, 1);
    add(0, 0, 5'b00010, 4'd3, 5'b00010, 1, 1, 5'd0, UF_AFTER);
    add(0, 0, 5'b00010, 4'd3, 5'b00010, 1, 1, 5'd0, UF_AFTER);
    add(1, 0, 5'b00000, 4'd0, 5'b00000, 1, 1, 5'd0, 0);
    add(0, 0, 5'b00000, 4'd0, 5'b00000, 1, 1, 5'd0, 0);
    // Pop landing on the same edge as a write update keeps level 1.
    add(0, 0, 5'b00001, 4'd0, 5'b00000, 0, 1, 5'd1, 0);
    add(0, 1, 5'b00011, 4'd1, 5'b00001, 0, 1, 5'd1, 0);
    add(0, 0, 5'b00011, 4'd1, 5'b00001, 0, 1, 5'd1, 0);
    add(0, 1, 5'b00011, 4'd2, 5'b00011, 1, 1, 5'd0, 0);
    run_vecs("seq");

    // Full FIFO: level 16, then 16 pops wrapping the address.
    clear_state();
    add(0, 0, 5'b11000, 4'd0, 5'b00000, 0, 0, 5'd16, 0);
    for (int k = 1; k <= 16; k++) begin
      add(0, 1, 5'b11000, 4'(k % 16), gray_tab[k], (k == 16), ((16 - k) <= 2),
          5'(16 - k), 0);
    end
    run_vecs("wrap");

    // Gray pointer moves by exactly one bit per pop across a full lap.
    clear_state();
    @(negedge rd_clk);
    sync_wrt_ptr = 5'b11000;
    @(negedge rd_clk);
    prev_ptr = rd_ptr;
    rd_inc = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(posedge rd_clk);
      #1;
      check($sformatf("onebit[%0d]", k), 32'($countones(rd_ptr ^ prev_ptr)), 32'd1);
      prev_ptr = rd_ptr;
    end
    rd_inc = 1'b0;

    // Reset mid-operation: level 5, two pops, then reset held with rd_inc high.
    clear_state();
    add(0, 0, 5'b00111, 4'd0, 5'b00000, 0, 0, 5'd5, 0);
    add(0, 1, 5'b00111, 4'd1, 5'b00001, 0, 0, 5'd4, 0);
    add(0, 1, 5'b00111, 4'd2, 5'b00011, 0, 0, 5'd3, 0);
    run_vecs("midrst");
    @(negedge rd_clk);
    rd_rst = 1'b1;
    rd_inc = 1'b1;
    #1;
    check_reset_vals("midrst_async");
    @(posedge rd_clk);
    #1;
    check_reset_vals("midrst_hold");
    @(negedge rd_clk);
    rd_rst = 1'b0;
    rd_inc = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/read_pointer_gen.md
Name: read_pointer_gen

Overview:
- Read-side pointer and flag generator for the asynchronous FIFO. Mirror of the write-side pointer logic.
- Advances a binary read address and a Gray-coded read pointer that crosses to the write domain.
- Computes a registered empty flag from the write pointer after it is synchronised into the read domain.
- Also provides a registered fill level, an almost-empty flag and underflow reporting, all in the read clock domain.

Parameters:
- ADDR_SIZE, 4, memory address width; FIFO depth = 2**ADDR_SIZE.
- AE_THRESH, 2, almost-empty threshold in words (0 .. 2**ADDR_SIZE).

Ports:
- rd_clk  input  1  read-domain clock.
- rd_rst  input  1  asynchronous, active-high reset.
- rd_inc  input  1  read request; pops one word when not empty.
- sync_wrt_ptr  input  ADDR_SIZE+1  Gray write pointer, already synchronised into rd_clk.
- rd_addr  output  ADDR_SIZE  binary read address to the FIFO memory.
- rd_ptr  output  ADDR_SIZE+1  registered Gray read pointer, sent to the write-side synchroniser.
- rd_empty  output  1  registered empty flag.
- rd_almost_empty  output  1  registered; high when level <= AE_THRESH.
- rd_level  output  ADDR_SIZE+1  registered word count, 0 .. 2**ADDR_SIZE.
- rd_underflow  output  1  reports rd_inc while empty.

Behaviour:
- One clock, rd_clk. Asynchronous active-high reset rd_rst.
- Reset values (applied immediately on assertion, held while rd_rst is high):
  - rd_bin = 0, rd_ptr = 0, rd_addr = 0
  - rd_empty = 1, rd_almost_empty = 1
  - rd_level = 0, rd_underflow = 0
- Pointer update:
  - rd_bin_nxt = rd_bin + (rd_inc & ~rd_empty), modulo 2**(ADDR_SIZE+1).
  - rd_gray_nxt = (rd_bin_nxt >> 1) ^ rd_bin_nxt.
  - On each rising edge: {rd_bin, rd_ptr} <= {rd_bin_nxt, rd_gray_nxt}.
  - rd_addr = rd_bin[ADDR_SIZE-1:0] (combinational from the register, so it changes with rd_bin).
- Empty:
  - rd_empty <= (rd_gray_nxt == sync_wrt_ptr), registered.
  - The pop that drains the last word sets rd_empty on the same edge that rd_ptr advances. Zero-cycle lag on the read side.
  - A write becomes visible one rd_clk edge after sync_wrt_ptr changes.
- Level:
  - wbin = Gray-to-binary(sync_wrt_ptr): wbin[i] = XOR of sync_wrt_ptr[ADDR_SIZE:i].
  - level_nxt = (wbin - rd_bin_nxt) mod 2**(ADDR_SIZE+1). Valid range 0 .. 2**ADDR_SIZE.
  - rd_level <= level_nxt.
  - rd_almost_empty <= (level_nxt <= AE_THRESH).
  - The level is conservative because the synchronised write pointer lags: it under-reports and never over-reports.
- Wrap-around:
  - rd_addr wraps from 2**ADDR_SIZE - 1 to 0.
  - rd_bin MSB toggles on each wrap. The Gray pointer changes exactly one bit per pop.
- Underflow:
  - rd_inc=1 while rd_empty=1 leaves the pointer unchanged and sets rd_underflow.
  - Default: rd_underflow is a one-cycle pulse, registered on the edge where the illegal request is sampled.
- Simultaneous events:
  - A pop and a write update landing on the same edge: both are folded into level_nxt and the empty compare. No special priority.
- Reset mid-operation: all state returns to the reset values asynchronously. Resuming after reset requires the write domain to be reset as well; this block does not check that.

Optional Feature:
- Macro RD_UNDERFLOW_STICKY_EN.
- Defined: rd_underflow is sticky. It sets on the first illegal pop and clears only on rd_rst.
- Undefined: rd_underflow is a single-cycle pulse per illegal rd_inc cycle (as described above).

Decomposition:
- Shared package fifo_pkg holds:
  - default ADDR_SIZE
  - functions bin2gray and gray2bin (parameterised width)
  - the depth constant 2**ADDR_SIZE
- The write-side pointer logic shares the same package.
- Natural sub-module: gray_to_bin. Purely combinational, parameter WIDTH, instantiated for the sync_wrt_ptr conversion.
- The rest stays flat in read_pointer_gen.

Test Plan:
All cases use ADDR_SIZE=4, AE_THRESH=2.
- Reset check: assert rd_rst between edges -> immediately rd_empty=1, rd_almost_empty=1, rd_ptr=5'b00000, rd_addr=0, rd_level=0, rd_underflow=0.
- Drain to empty:
  - Drive sync_wrt_ptr=5'b00010 (gray 3), rd_inc=0 -> next edge rd_empty=0, rd_level=3, rd_almost_empty=0.
  - Then 3 pops -> rd_addr 0→1→2→3. Levels are 2 (almost_empty=1), 1, 0. On the third-pop edge, rd_empty=1 and rd_ptr=5'b00010.
- Full and wrap:
  - sync_wrt_ptr=5'b11000 (gray 16), rd_bin=0 -> rd_level=16.
  - Pop 16 times -> rd_addr wraps 15→0, rd_ptr=5'b11000, rd_empty=1. rd_ptr changes exactly one bit per pop.
- Underflow:
  - While empty, hold rd_inc=1 for 2 cycles -> rd_ptr unchanged.
  - Without macro: rd_underflow high for exactly 2 cycles, then 0.
  - With RD_UNDERFLOW_STICKY_EN: stays 1 until rd_rst.
- Simultaneous events: level 1, pop on the same edge sync_wrt_ptr advances by 1 -> rd_empty stays 0, rd_level=1.
- Reset mid-operation: level 5 with pops in progress, pulse rd_rst -> all outputs return to reset values at once; no pointer advance while rd_rst is high.
